// File: rtl/buffer_dma_writer.sv
// buffer_dma_writer: descriptor-driven DMA write master for the buffer controller's
// DMA write port. One command (region, word offset, length) pulls that many beats
// from a source stream and issues address-mapped writes with valid/ready.
// Optional feature macro: BUFWR_AUTO_SWAP_EN -- activation commands target the bank
// not being read by compute (sampled at command accept), and swap_req_o pulses
// together with done_o when such a command completes.
module buffer_dma_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_region_i,
  input  logic [ADDR_WIDTH-1:0] cmd_offset_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  src_valid_i,
  input  logic [DATA_WIDTH-1:0] src_data_i,
  output logic                  src_ready_o,
  output logic                  dma_wr_valid_o,
  output logic [ADDR_WIDTH-1:0] dma_wr_addr_o,
  output logic [DATA_WIDTH-1:0] dma_wr_data_o,
  input  logic                  dma_wr_ready_i,
  input  logic                  ping_pong_sel_i,
  output logic                  swap_req_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [LEN_WIDTH-1:0]  beat_cnt_o
);

  // Range check width: offset + len can never wrap in this many bits.
  localparam int CW = LEN_WIDTH + ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                state_q;
  logic                  cmd_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  wr_valid_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [LEN_WIDTH-1:0]  beat_cnt_q;

  logic [1:0]            region_d;
  logic [ADDR_WIDTH-1:0] base_d;
  logic [CW-1:0]         size_d;
  logic [CW-1:0]         end_d;
  logic                  legal_d;
  logic                  src_fire;
  logic                  wr_fire;

`ifdef BUFWR_AUTO_SWAP_EN
  logic act_q;
  logic swap_q;
  logic is_act_d;
`else
  logic unused_sel;
  assign unused_sel = ping_pong_sel_i;
`endif

  // Region decode: effective bank, base address, size and legality of the offered command.
  always_comb begin
    region_d = cmd_region_i;
`ifdef BUFWR_AUTO_SWAP_EN
    is_act_d = (cmd_region_i == 2'd1) || (cmd_region_i == 2'd2);
    // Both activation regions land in the bank compute is not reading.
    if (is_act_d) begin
      region_d = ping_pong_sel_i ? 2'd1 : 2'd2;
    end
`endif
    case (region_d)
      2'd0:    begin base_d = ADDR_WIDTH'(32'h0000_0000); size_d = CW'(32'h0002_0000); end
      2'd1:    begin base_d = ADDR_WIDTH'(32'h0002_0000); size_d = CW'(32'h0001_0000); end
      2'd2:    begin base_d = ADDR_WIDTH'(32'h0003_0000); size_d = CW'(32'h0001_0000); end
      default: begin base_d = ADDR_WIDTH'(32'h0004_0000); size_d = CW'(32'h0000_8000); end
    endcase
    end_d   = CW'(cmd_offset_i) + CW'(cmd_len_i);
    legal_d = (cmd_len_i != '0) && (end_d <= size_d);
  end

  assign src_ready_o = (state_q == ST_XFER) && (remaining_q != '0) &&
                       (!wr_valid_q || dma_wr_ready_i);
  assign src_fire    = src_valid_i && src_ready_o;
  assign wr_fire     = wr_valid_q && dma_wr_ready_i;

  // Command FSM with the write output register and all registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
`ifdef BUFWR_AUTO_SWAP_EN
      act_q       <= 1'b0;
      swap_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef BUFWR_AUTO_SWAP_EN
      swap_q <= 1'b0;
`endif
      if (wr_fire) begin
        beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            beat_cnt_q <= '0;
            err_q      <= !legal_d;
            if (legal_d) begin
              addr_q      <= base_d + cmd_offset_i;
              remaining_q <= cmd_len_i;
              state_q     <= ST_XFER;
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
`ifdef BUFWR_AUTO_SWAP_EN
              act_q       <= is_act_d;
`endif
            end else begin
              // Rejected command completes immediately without leaving IDLE.
              done_q <= 1'b1;
            end
          end
        end
        ST_XFER: begin
          // A pop reloads the output register even while the previous beat is
          // being accepted, so back-to-back beats flow without a bubble.
          if (src_fire) begin
            wr_valid_q  <= 1'b1;
            wr_addr_q   <= addr_q;
            wr_data_q   <= src_data_i;
            addr_q      <= addr_q + ADDR_WIDTH'(1);
            remaining_q <= remaining_q - LEN_WIDTH'(1);
            if (remaining_q == LEN_WIDTH'(1)) begin
              state_q <= ST_DRAIN;
            end
          end else if (wr_fire) begin
            wr_valid_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (wr_fire) begin
            wr_valid_q <= 1'b0;
            state_q    <= ST_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
`ifdef BUFWR_AUTO_SWAP_EN
            swap_q     <= act_q;
`endif
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign dma_wr_valid_o = wr_valid_q;
  assign dma_wr_addr_o  = wr_addr_q;
  assign dma_wr_data_o  = wr_data_q;
  assign beat_cnt_o     = beat_cnt_q;
`ifdef BUFWR_AUTO_SWAP_EN
  assign swap_req_o     = swap_q;
`else
  assign swap_req_o     = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_dma_writer.sv
// tb_buffer_dma_writer: table-driven and randomized checks of buffer_dma_writer against
// a transaction-level model (region map arithmetic plus a queue of popped source beats).
module tb_buffer_dma_writer;

`ifdef BUFWR_AUTO_SWAP_EN
  localparam bit AUTO_SWAP = 1'b1;
`else
  localparam bit AUTO_SWAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready_o;
  logic [1:0]  cmd_region;
  logic [31:0] cmd_offset;
  logic [15:0] cmd_len;
  logic        src_valid;
  logic [31:0] src_data;
  logic        src_ready_o;
  logic        dma_wr_valid_o;
  logic [31:0] dma_wr_addr_o;
  logic [31:0] dma_wr_data_o;
  logic        dma_wr_ready;
  logic        ping_pong_sel;
  logic        swap_req_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] beat_cnt_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  buffer_dma_writer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_region_i   (cmd_region),
    .cmd_offset_i   (cmd_offset),
    .cmd_len_i      (cmd_len),
    .src_valid_i    (src_valid),
    .src_data_i     (src_data),
    .src_ready_o    (src_ready_o),
    .dma_wr_valid_o (dma_wr_valid_o),
    .dma_wr_addr_o  (dma_wr_addr_o),
    .dma_wr_data_o  (dma_wr_data_o),
    .dma_wr_ready_i (dma_wr_ready),
    .ping_pong_sel_i(ping_pong_sel),
    .swap_req_o     (swap_req_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .beat_cnt_o     (beat_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference region map.
  function automatic logic [1:0] ref_region(input logic [1:0] r, input logic sel);
    if (AUTO_SWAP && (r == 2'd1 || r == 2'd2)) return sel ? 2'd1 : 2'd2;
    return r;
  endfunction

  function automatic logic [31:0] ref_base(input logic [1:0] e);
    case (e)
      2'd0:    return 32'h0000_0000;
      2'd1:    return 32'h0002_0000;
      2'd2:    return 32'h0003_0000;
      default: return 32'h0004_0000;
    endcase
  endfunction

  function automatic logic [63:0] ref_size(input logic [1:0] e);
    case (e)
      2'd0:    return 64'h2_0000;
      2'd1:    return 64'h1_0000;
      2'd2:    return 64'h1_0000;
      default: return 64'h8000;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [1:0] r, input logic [31:0] off,
                                   input logic [15:0] len, input logic sel);
    logic [63:0] fin;
    fin = {32'b0, off} + {48'b0, len};
    return (len != 16'd0) && (fin <= ref_size(ref_region(r, sel)));
  endfunction

  // Issue one command and track it to completion plus two idle cycles.
  // rmode: 0 ready always, 1 ready toggles, 2 ready random; smode: 0 src always, 1 random.
  task automatic run_cmd(input logic [1:0] region, input logic [31:0] offset,
                         input logic [15:0] len, input int unsigned rmode,
                         input int unsigned smode, input logic sel,
                         input bit exp_err, input int unsigned exp_beats);
    logic [31:0] src_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] base;
    logic [31:0] ha, hd;
    bit          held, finished, exp_swap;
    int unsigned c, done_cnt, done_c, swap_cnt, viol, tail, bound, n;
    logic        busy1, rdy1;

    base     = ref_base(ref_region(region, sel));
    exp_swap = AUTO_SWAP && !exp_err && (region == 2'd1 || region == 2'd2);
    bound    = 40 + 16 * int'(len);
    if (bound > 400) bound = 400;
    held = 0; finished = 0; c = 0; done_cnt = 0; done_c = 0; swap_cnt = 0; viol = 0; tail = 0;
    busy1 = 1'bx; rdy1 = 1'bx;

    @(negedge clk);
    ping_pong_sel = sel;
    cmd_valid     = 1'b1;
    cmd_region    = region;
    cmd_offset    = offset;
    cmd_len       = len;
    src_valid     = 1'b0;
    dma_wr_ready  = 1'b1;
    #1;
    chk("cmd_ready_before", {63'b0, cmd_ready_o}, 64'd1);
    @(posedge clk);

    while (!finished) begin
      @(negedge clk);
      c++;
      cmd_valid     = 1'b0;
      cmd_region    = 2'($urandom);
      cmd_offset    = $urandom;
      cmd_len       = 16'($urandom);
      ping_pong_sel = 1'($urandom);
      src_valid     = (smode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      src_data      = $urandom;
      dma_wr_ready  = (rmode == 0) ? 1'b1 : (rmode == 1) ? c[0] : 1'($urandom_range(0, 1));
      #1;
      if (c == 1) begin busy1 = busy_o; rdy1 = cmd_ready_o; end
      if (held && (!dma_wr_valid_o || dma_wr_addr_o !== ha || dma_wr_data_o !== hd)) viol++;
      held = 0;
      if (dma_wr_valid_o) begin
        if (dma_wr_ready) begin
          wa_q.push_back(dma_wr_addr_o);
          wd_q.push_back(dma_wr_data_o);
        end else begin
          held = 1; ha = dma_wr_addr_o; hd = dma_wr_data_o;
        end
      end
      if (src_valid && src_ready_o) src_q.push_back(src_data);
      if (done_o) begin
        done_cnt++;
        if (done_c == 0) done_c = c;
      end
      if (swap_req_o) begin
        swap_cnt++;
        if (!done_o) viol++;
      end
      if (done_cnt > 0) tail++;
      if (tail == 3 || c >= bound) finished = 1;
    end

    chk("done_seen", {63'b0, done_cnt != 0}, 64'd1);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("busy_first_cycle", {63'b0, busy1}, {63'b0, !exp_err});
    chk("cmd_ready_first_cycle", {63'b0, rdy1}, {63'b0, exp_err});
    if (exp_err || (rmode == 0 && smode == 0))
      chk("done_latency", 64'(done_c), exp_err ? 64'd1 : 64'(len) + 64'd2);
    chk("err", {63'b0, err_o}, {63'b0, exp_err});
    chk("beat_cnt", 64'(beat_cnt_o), 64'(exp_beats));
    chk("write_count", 64'(wa_q.size()), 64'(exp_beats));
    chk("src_pops", 64'(src_q.size()), 64'(exp_beats));
    chk("stall_hold", 64'(viol), 64'd0);
    chk("swap_pulses", 64'(swap_cnt), {63'b0, exp_swap});
    chk("cmd_ready_after", {63'b0, cmd_ready_o}, 64'd1);
    chk("busy_after", {63'b0, busy_o}, 64'd0);
    n = wa_q.size();
    if (src_q.size() < n) n = src_q.size();
    for (int i = 0; i < int'(n); i++) begin
      chk("wr_addr", 64'(wa_q[i]), 64'(base + offset + 32'(i)));
      chk("wr_data", 64'(wd_q[i]), 64'(src_q[i]));
    end
  endtask

  typedef struct {
    logic [1:0]  region;
    logic [31:0] offset;
    logic [15:0] len;
    int unsigned rmode;
    int unsigned smode;
    bit          exp_err;
    int unsigned exp_beats;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [1:0]  r;
    logic [31:0] off;
    logic [15:0] len;
    logic        sel;
    logic [63:0] sz;
    bit          legal;
    int unsigned m;

    rst = 1'b1; cmd_valid = 1'b0; cmd_region = '0; cmd_offset = '0; cmd_len = '0;
    src_valid = 1'b0; src_data = '0; dma_wr_ready = 1'b0; ping_pong_sel = 1'b0;

    vecs[0] = '{2'd0, 32'h0000_0010, 16'd4,  0, 0, 1'b0, 4};
    vecs[1] = '{2'd3, 32'h0000_0000, 16'd8,  1, 0, 1'b0, 8};
    vecs[2] = '{2'd3, 32'h0000_7FFE, 16'd3,  0, 0, 1'b1, 0};
    vecs[3] = '{2'd3, 32'h0000_7FFD, 16'd3,  0, 0, 1'b0, 3};
    vecs[4] = '{2'd1, 32'h0000_0000, 16'd0,  0, 0, 1'b1, 0};
    vecs[5] = '{2'd2, 32'h0000_FFFF, 16'd1,  1, 1, 1'b0, 1};
    vecs[6] = '{2'd0, 32'h0001_FFFF, 16'd2,  0, 0, 1'b1, 0};
    vecs[7] = '{2'd1, 32'hFFFF_FFFF, 16'd1,  0, 0, 1'b1, 0};
    vecs[8] = '{2'd0, 32'h0001_FFF0, 16'd16, 2, 1, 1'b0, 16};
    vecs[9] = '{2'd1, 32'h0000_0000, 16'd2,  0, 0, 1'b0, 2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_cmd_ready", {63'b0, cmd_ready_o}, 64'd1);
    chk("rst_wr_valid", {63'b0, dma_wr_valid_o}, 64'd0);
    chk("rst_src_ready", {63'b0, src_ready_o}, 64'd0);
    chk("rst_flags", {60'b0, busy_o, done_o, err_o, swap_req_o}, 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt_o), 64'd0);
    chk("rst_wr_addr_data", {dma_wr_addr_o, dma_wr_data_o}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_cmd(vecs[i].region, vecs[i].offset, vecs[i].len, vecs[i].rmode, vecs[i].smode,
              1'b0, vecs[i].exp_err, vecs[i].exp_beats);

    // Reset in the middle of a 5-beat activation command after two accepted writes.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_region = 2'd1; cmd_offset = 32'h40; cmd_len = 16'd5;
    src_valid = 1'b1; dma_wr_ready = 1'b1; ping_pong_sel = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      src_data  = $urandom;
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    chk("pre_rst_beat_cnt", 64'(beat_cnt_o), 64'd2);
    chk("pre_rst_wr_valid", {63'b0, dma_wr_valid_o}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("mid_rst_cmd_ready", {63'b0, cmd_ready_o}, 64'd1);
    chk("mid_rst_wr_valid", {63'b0, dma_wr_valid_o}, 64'd0);
    chk("mid_rst_flags", {60'b0, busy_o, done_o, err_o, swap_req_o}, 64'd0);
    chk("mid_rst_beat_cnt", 64'(beat_cnt_o), 64'd0);
    chk("mid_rst_wr_addr_data", {dma_wr_addr_o, dma_wr_data_o}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_write", {62'b0, dma_wr_valid_o, src_ready_o}, 64'd0);
    end

    // Randomized commands against the reference model.
    for (int k = 0; k < 40; k++) begin
      r   = 2'($urandom_range(0, 3));
      sel = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
      m   = $urandom_range(0, 7);
      sz  = ref_size(ref_region(r, sel));
      if (m < 4)      off = 32'($urandom_range(0, 256));
      else if (m < 7) off = 32'(sz) - 32'($urandom_range(0, 24));
      else            off = $urandom;
      legal = ref_legal(r, off, len, sel);
      run_cmd(r, off, len, $urandom_range(0, 2), $urandom_range(0, 1), sel,
              !legal, legal ? int'(len) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
